// File: rtl/msg_uart_tx.sv
// msg_uart_tx: serialises the phone status and message/cost display as one
// 18-byte UART frame (8N1) whenever either input changes. A frame is
// 16 display characters followed by CR LF. Changes arriving while a frame is
// in flight are folded into a single follow-up frame.
module msg_uart_tx #(
    parameter int CLKS_PER_BIT = 868
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [63:0] statusMsg,
    input  logic [63:0] sentMsg,
    output logic        tx,
    output logic        busy,
    output logic        frame_done,
    output logic [7:0]  frame_cnt
);

    localparam int                BAUD_W     = $clog2(CLKS_PER_BIT);
    localparam logic [BAUD_W-1:0] BAUD_LAST  = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [63:0]       STATUS_RST = "IDLE    ";
    localparam logic [63:0]       SENT_RST   = {8{8'h20}};
    localparam logic [4:0]        LAST_BYTE  = 5'd17;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        START,
        DATA,
        STOP
    } state_t;

    state_t              state_q;
    logic [63:0]         prev_status_q;
    logic [63:0]         prev_sent_q;
    logic                pending_q;
    logic                pending_d;
    logic                change;
    logic [127:0]        frame_q;
    logic [127:0]        frame_shifted;
    logic [7:0]          cur_byte;
    logic [4:0]          byte_idx_q;
    logic [2:0]          bit_cnt_q;
    logic [BAUD_W-1:0]   baud_q;
    logic                tx_q;
    logic                busy_q;
    logic                frame_done_q;
    logic [7:0]          frame_cnt_q;

    // Change detection: a newly seen change always re-arms pending, even in
    // the LOAD cycle that would otherwise clear it, so no update is lost.
    always_comb begin
        change    = (statusMsg != prev_status_q) || (sentMsg != prev_sent_q);
        pending_d = pending_q;
        if (state_q == LOAD) begin
            pending_d = 1'b0;
        end
        if (change) begin
            pending_d = 1'b1;
        end
    end

    // Byte currently on the wire: 16 buffered characters, then CR, then LF.
    always_comb begin
        frame_shifted = frame_q << {byte_idx_q, 3'b000};
        cur_byte      = frame_shifted[127:120];
        if (byte_idx_q == 5'd16) begin
            cur_byte = 8'h0D;
        end else if (byte_idx_q == LAST_BYTE) begin
            cur_byte = 8'h0A;
        end
    end

    // Track the previous input values and the pending-frame flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            prev_status_q <= STATUS_RST;
            prev_sent_q   <= SENT_RST;
            pending_q     <= 1'b1;
        end else begin
            prev_status_q <= statusMsg;
            prev_sent_q   <= sentMsg;
            pending_q     <= pending_d;
        end
    end

    // Transmit FSM: snapshot, then start/data/stop per byte, bytes back-to-back.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            frame_q      <= '0;
            byte_idx_q   <= '0;
            bit_cnt_q    <= '0;
            baud_q       <= '0;
            tx_q         <= 1'b1;
            busy_q       <= 1'b0;
            frame_done_q <= 1'b0;
            frame_cnt_q  <= '0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tx_q <= 1'b1;
                    if (pending_q) begin
                        state_q <= LOAD;
                        busy_q  <= 1'b1;
                    end
                end
                LOAD: begin
                    frame_q    <= {statusMsg, sentMsg};
                    byte_idx_q <= '0;
                    bit_cnt_q  <= '0;
                    baud_q     <= '0;
                    tx_q       <= 1'b0;
                    state_q    <= START;
                end
                START: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q    <= '0;
                        bit_cnt_q <= '0;
                        tx_q      <= cur_byte[0];
                        state_q   <= DATA;
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                DATA: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (bit_cnt_q == 3'd7) begin
                            tx_q    <= 1'b1;
                            state_q <= STOP;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                            tx_q      <= cur_byte[3'(bit_cnt_q + 3'd1)];
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                STOP: begin
                    if (baud_q == BAUD_LAST) begin
                        baud_q <= '0;
                        if (byte_idx_q == LAST_BYTE) begin
                            byte_idx_q   <= '0;
                            state_q      <= IDLE;
                            busy_q       <= 1'b0;
                            frame_done_q <= 1'b1;
                            frame_cnt_q  <= frame_cnt_q + 8'd1;
                        end else begin
                            byte_idx_q <= byte_idx_q + 5'd1;
                            tx_q       <= 1'b0;
                            state_q    <= START;
                        end
                    end else begin
                        baud_q <= baud_q + BAUD_W'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                    tx_q    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = tx_q;
    assign busy       = busy_q;
    assign frame_done = frame_done_q;
    assign frame_cnt  = frame_cnt_q;

endmodule

// File: tb/tb_msg_uart_tx.sv
// Directed testbench for msg_uart_tx with CLKS_PER_BIT=4.
module tb_msg_uart_tx;

    localparam int CPB = 4;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [63:0] statusMsg = "IDLE    ";
    logic [63:0] sentMsg   = {8{8'h20}};
    logic        tx;
    logic        busy;
    logic        frame_done;
    logic [7:0]  frame_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;
    int fall_cyc = 0;
    int done_cyc = 0;
    logic [7:0] rxb [18];

    msg_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk        (clk),
        .rst        (rst),
        .statusMsg  (statusMsg),
        .sentMsg    (sentMsg),
        .tx         (tx),
        .busy       (busy),
        .frame_done (frame_done),
        .frame_cnt  (frame_cnt)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [143:0] obs, input logic [143:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Wait (at negedges) until tx is low, bounded by limit cycles.
    task automatic wait_low(input int limit, output bit ok);
        int i;
        ok = 1'b0;
        i  = 0;
        while (!ok && i < limit) begin
            if (tx === 1'b0) ok = 1'b1;
            else begin
                @(negedge clk);
                i++;
            end
        end
    endtask

    // Receive one 18-byte frame into rxb, then wait for frame_done.
    task automatic rx_frame();
        bit ok;
        bit alive;
        alive = 1'b1;
        for (int k = 0; k < 18; k++) begin
            if (alive) begin
                wait_low(5000, ok);
                if (!ok) begin
                    check("rx_start_timeout", 144'(ok), 144'd1);
                    alive = 1'b0;
                end else begin
                    if (k == 0) fall_cyc = cyc;
                    repeat (CPB / 2) @(negedge clk);
                    for (int b = 0; b < 8; b++) begin
                        repeat (CPB) @(negedge clk);
                        rxb[k][b] = tx;
                    end
                    repeat (CPB) @(negedge clk);
                end
            end
        end
        if (alive) begin
            ok = 1'b0;
            for (int i = 0; i < 20; i++) begin
                if (!ok) begin
                    @(negedge clk);
                    if (frame_done === 1'b1) begin
                        ok = 1'b1;
                        done_cyc = cyc;
                    end
                end
            end
            check("frame_done_seen", 144'(ok), 144'd1);
        end
    endtask

    function automatic logic [143:0] packed_rx();
        logic [143:0] p;
        p = '0;
        for (int k = 0; k < 18; k++) p = {p[135:0], rxb[k]};
        return p;
    endfunction

    initial begin
        int bad;
        bit ok;
        logic [39:0] wave;
        logic [7:0]  cnt0;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 144'(tx), 144'd1);
        check("rst_busy", 144'(busy), 144'd0);
        check("rst_frame_done", 144'(frame_done), 144'd0);
        check("rst_frame_cnt", 144'(frame_cnt), 144'd0);

        // First frame after release
        rst = 1'b0;
        @(negedge clk);
        check("rel_busy_load", 144'(busy), 144'd1);
        check("rel_tx_load", 144'(tx), 144'd1);
        @(negedge clk);
        check("rel_tx_fall", 144'(tx), 144'd0);
        rx_frame();
        check("frame1_bytes", packed_rx(), 144'h4944_4C45_2020_2020_2020_2020_2020_2020_0D0A);
        check("frame1_len", 144'(done_cyc - fall_cyc), 144'd720);
        check("frame1_cnt", 144'(frame_cnt), 144'd1);
        @(negedge clk);
        check("frame_done_width", 144'(frame_done), 144'd0);
        check("frame1_idle_busy", 144'(busy), 144'd0);

        // Stable inputs: line stays idle
        bad = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0 || frame_cnt !== 8'd1) bad++;
        end
        check("stable_idle_bad_cycles", 144'(bad), 144'd0);

        // Status change while idle
        statusMsg = "RINGING ";
        @(negedge clk);
        check("ring_e0_tx", 144'(tx), 144'd1);
        check("ring_e0_busy", 144'(busy), 144'd0);
        @(negedge clk);
        check("ring_e1_busy", 144'(busy), 144'd1);
        check("ring_e1_tx", 144'(tx), 144'd1);
        @(negedge clk);
        check("ring_e2_tx", 144'(tx), 144'd0);
        rx_frame();
        check("ring_bytes", packed_rx(), 144'h5249_4E47_494E_4720_2020_2020_2020_2020_0D0A);
        check("ring_cnt", 144'(frame_cnt), 144'd2);

        // Three sentMsg changes during one frame
        statusMsg = "CALLING ";
        fork
            rx_frame();
            begin
                repeat (20) @(negedge clk);
                sentMsg = "XYZ     ";
                repeat (50) @(negedge clk);
                sentMsg = "MSG1    ";
                repeat (50) @(negedge clk);
                sentMsg = "ABC     ";
            end
        join
        check("inflight_bytes", packed_rx(), 144'h4341_4C4C_494E_4720_2020_2020_2020_2020_0D0A);
        check("inflight_len", 144'(done_cyc - fall_cyc), 144'd720);
        rx_frame();
        check("followup_bytes", packed_rx(), 144'h4341_4C4C_494E_4720_4142_4320_2020_2020_0D0A);
        check("followup_cnt", 144'(frame_cnt), 144'd4);
        bad = 0;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (busy !== 1'b0 || tx !== 1'b1) bad++;
        end
        check("no_third_frame", 144'(bad), 144'd0);

        // Bit-exact waveform of byte 8'h35
        statusMsg = "5TATUS  ";
        wait_low(100, ok);
        check("byte35_start_seen", 144'(ok), 144'd1);
        for (int i = 0; i < 40; i++) begin
            wave[39 - i] = tx;
            @(negedge clk);
        end
        check("byte35_wave", 144'(wave), 144'h0F0F0FF00F);
        ok = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            if (!ok) begin
                @(negedge clk);
                if (frame_done === 1'b1) ok = 1'b1;
            end
        end
        check("byte35_frame_done", 144'(ok), 144'd1);
        check("byte35_cnt", 144'(frame_cnt), 144'd5);

        // Reset during data bit 3 of byte 5 ('S' = 8'h53, bit 3 is 0)
        statusMsg = "RESETS  ";
        wait_low(100, ok);
        check("rstmid_start_seen", 144'(ok), 144'd1);
        cnt0 = frame_cnt;
        repeat (5 * 10 * CPB + 4 * CPB + CPB / 2) @(negedge clk);
        check("rstmid_bit3_low", 144'(tx), 144'd0);
        check("rstmid_busy_before", 144'(busy), 144'd1);
        #2 rst = 1'b1;
        #1;
        check("rstmid_tx_async", 144'(tx), 144'd1);
        check("rstmid_busy_async", 144'(busy), 144'd0);
        check("rstmid_cnt_async", 144'(frame_cnt), 144'd0);
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        check("rstmid_held_idle", 144'(bad), 144'd0);
        rst = 1'b0;
        rx_frame();
        check("rstmid_fresh_bytes", packed_rx(), 144'h5245_5345_5453_2020_4142_4320_2020_2020_0D0A);
        check("rstmid_fresh_cnt", 144'(frame_cnt), 144'd1);
        check("rstmid_prior_cnt", 144'(cnt0), 144'd5);
        bad = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (busy !== 1'b0) bad++;
        end
        check("rstmid_single_frame", 144'(bad), 144'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
